multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequencing FSM for a multicycle RV32-subset datapath. Walks each
//   instruction through FETCH/DECODE/EXEC/MEM/WB, waits on MemReady with a
//   bounded wait counter, and parks in TRAP on an illegal opcode or a
//   memory timeout until TrapAck.
//
//   state  | meaning
//   FETCH  | read instruction memory, load IR and advance PC on MemReady
//   DECODE | latch opcode, check legality
//   EXEC   | drive ALU controls for the latched opcode
//   MEM    | load/store access, wait for MemReady
//   WB     | register file write (one cycle)
//   TRAP   | all controls idle, hold TrapCause until TrapAck
//
// Parameters
//   TIMEOUT  cycles waited for MemReady before trapping (1..255)
//   CNT_W    wait-counter width, 2^CNT_W-1 >= TIMEOUT
// Optional feature
//   MULTICYCLE_BRANCH_EN  when defined, BEQ (1100011) is legal and resolves
//                         in EXEC; otherwise BEQ traps and BranchTaken is 0.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   Opcode, Zero, MemReady,  instruction opcode, ALU zero flag, memory
//   TrapAck                  handshake, trap acknowledge
//   ALUOp, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, PCWrite,
//   IRWrite, BranchTaken     datapath controls
//   Trap, TrapCause, State   trap status and debug state code
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  input  logic       TrapAck,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       BranchTaken,
  output logic       Trap,
  output logic [1:0] TrapCause,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t           state, state_nxt;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_q, cause_nxt;
  logic             wait_expired;
  logic             op_legal;

  logic [1:0] alu_op;
  logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic       pc_write, ir_write, branch_taken;

  // Counter sits at TIMEOUT-1 during the TIMEOUT-th waiting cycle, so a
  // trap is taken after exactly TIMEOUT cycles without MemReady.
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    op_legal = 1'b0;
    case (Opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE: op_legal = 1'b1;
`ifdef MULTICYCLE_BRANCH_EN
      OP_BEQ:                        op_legal = 1'b1;
`endif
      default:                       op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      op_q     <= 7'b0000000;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == S_DECODE) op_q <= Opcode;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (state == S_FETCH || state == S_MEM) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause_q;
    alu_op       = 2'b00;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    branch_taken = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (MemReady) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_expired) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op    = 2'b10;
            state_nxt = S_WB;
          end
          OP_I: begin
            alu_op    = 2'b00;
            alu_src   = 1'b1;
            state_nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op    = 2'b01;
            alu_src   = 1'b1;
            state_nxt = S_MEM;
          end
`ifdef MULTICYCLE_BRANCH_EN
          OP_BEQ: begin
            alu_op       = 2'b11;
            branch_taken = Zero;
            pc_write     = Zero;
            state_nxt    = S_FETCH;
          end
`endif
          default: begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (op_q == OP_LOAD) mem_read = 1'b1;
        else                 mem_write = 1'b1;
        // Ready wins over an expiring counter in the same cycle.
        if (MemReady) begin
          state_nxt = (op_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        state_nxt  = S_FETCH;
      end
      S_TRAP: begin
        if (TrapAck) begin
          state_nxt = S_FETCH;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: begin
        state_nxt = S_TRAP;
        cause_nxt = CAUSE_ILLEGAL;
      end
    endcase
  end

`ifndef MULTICYCLE_BRANCH_EN
  logic unused_zero;
  assign unused_zero = Zero;
`endif

  // Reset forces FETCH, whose decode would raise MemRead; mask every control
  // while rst is high so nothing is driven until release.
  assign ALUOp       = rst ? 2'b00 : alu_op;
  assign ALUSrc      = alu_src      & ~rst;
  assign MemtoReg    = mem_to_reg   & ~rst;
  assign RegWrite    = reg_write    & ~rst;
  assign MemRead     = mem_read     & ~rst;
  assign MemWrite    = mem_write    & ~rst;
  assign PCWrite     = pc_write     & ~rst;
  assign IRWrite     = ir_write     & ~rst;
`ifdef MULTICYCLE_BRANCH_EN
  assign BranchTaken = branch_taken & ~rst;
`else
  assign BranchTaken = 1'b0;
`endif
  assign Trap        = (state == S_TRAP) & ~rst;
  assign TrapCause   = rst ? CAUSE_NONE : cause_q;
  assign State       = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Opcode;
  logic       Zero, MemReady, TrapAck;
  logic [1:0] ALUOp;
  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, PCWrite, IRWrite, BranchTaken;
  logic       Trap;
  logic [1:0] TrapCause;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .TrapAck(TrapAck), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .BranchTaken(BranchTaken), .Trap(Trap), .TrapCause(TrapCause),
    .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1ns+ after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Opcode = 7'd0; Zero = 1'b0; MemReady = 1'b1; TrapAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",    State,     3'd0);
    check("rst_memread",  MemRead,   1'b0);
    check("rst_irwrite",  IRWrite,   1'b0);
    check("rst_trap",     Trap,      1'b0);
    check("rst_cause",    TrapCause, 2'b00);
    rst = 1'b0;
    #1;
    check("post_rst_memread", MemRead, 1'b1);

    // R-type, zero-wait memory
    Opcode = 7'b0110011;
    check("r_fetch_irwrite", IRWrite, 1'b1);
    check("r_fetch_pcwrite", PCWrite, 1'b1);
    tick();
    check("r_decode_state", State, 3'd1);
    check("r_decode_regwr", RegWrite, 1'b0);
    tick();
    check("r_exec_state", State, 3'd2);
    check("r_exec_aluop", ALUOp, 2'b10);
    check("r_exec_alusrc", ALUSrc, 1'b0);
    check("r_exec_regwr", RegWrite, 1'b0);
    tick();
    check("r_wb_state", State, 3'd4);
    check("r_wb_regwr", RegWrite, 1'b1);
    check("r_wb_memtoreg", MemtoReg, 1'b0);
    tick();
    check("r_back_fetch", State, 3'd0);
    check("r_fetch_regwr", RegWrite, 1'b0);

    // I-type
    Opcode = 7'b0010011;
    tick(); tick();
    check("i_exec_aluop", ALUOp, 2'b00);
    check("i_exec_alusrc", ALUSrc, 1'b1);
    tick();
    check("i_wb_state", State, 3'd4);
    tick();

    // Load, MemReady low for 3 MEM cycles
    Opcode = 7'b0000011;
    tick(); tick();
    check("ld_exec_aluop", ALUOp, 2'b01);
    check("ld_exec_alusrc", ALUSrc, 1'b1);
    MemReady = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("ld_mem_wait_state", State, 3'd3);
      check("ld_mem_wait_memread", MemRead, 1'b1);
    end
    tick();
    MemReady = 1'b1;
    #1;
    check("ld_mem4_memread", MemRead, 1'b1);
    tick();
    check("ld_wb_state", State, 3'd4);
    check("ld_wb_memtoreg", MemtoReg, 1'b1);
    check("ld_wb_regwr", RegWrite, 1'b1);
    check("ld_no_trap", Trap, 1'b0);
    tick();
    check("ld_back_fetch", State, 3'd0);

    // Store, MemReady never comes: trap after 16 MEM cycles
    Opcode = 7'b0100011;
    tick(); tick();
    check("st_exec_aluop", ALUOp, 2'b01);
    MemReady = 1'b0;
    tick();
    check("st_mem1_memwrite", MemWrite, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("st_mem_wait_state", State, 3'd3);
    end
    check("st_mem16_memwrite", MemWrite, 1'b1);
    tick();
    check("st_to_state", State, 3'd5);
    check("st_to_trap", Trap, 1'b1);
    check("st_to_cause", TrapCause, 2'b10);
    check("st_to_memwrite", MemWrite, 1'b0);
    tick();
    check("st_to_hold_cause", TrapCause, 2'b10);
    TrapAck = 1'b1;
    tick();
    TrapAck = 1'b0;
    MemReady = 1'b1;
    #1;
    check("st_ack_state", State, 3'd0);
    check("st_ack_cause", TrapCause, 2'b00);

    // Store: MemReady arrives exactly on the 16th MEM cycle, ready wins
    tick(); tick();
    MemReady = 1'b0;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    MemReady = 1'b1;
    #1;
    check("edge_mem16_state", State, 3'd3);
    check("edge_mem16_memwrite", MemWrite, 1'b1);
    tick();
    check("edge_to_fetch", State, 3'd0);
    check("edge_no_trap", Trap, 1'b0);
    check("edge_cause", TrapCause, 2'b00);

    // Illegal opcode
    Opcode = 7'b1111111;
    tick();
    check("ill_decode_regwr", RegWrite, 1'b0);
    check("ill_decode_memwr", MemWrite, 1'b0);
    tick();
    check("ill_state", State, 3'd5);
    check("ill_cause", TrapCause, 2'b01);
    check("ill_regwr", RegWrite, 1'b0);
    check("ill_memwr", MemWrite, 1'b0);
    TrapAck = 1'b1;
    tick();
    TrapAck = 1'b0;
    #1;
    check("ill_ack_state", State, 3'd0);

    // BEQ
    Opcode = 7'b1100011;
`ifdef MULTICYCLE_BRANCH_EN
    Zero = 1'b1;
    tick(); tick();
    check("beq_z1_aluop", ALUOp, 2'b11);
    check("beq_z1_pcwrite", PCWrite, 1'b1);
    check("beq_z1_taken", BranchTaken, 1'b1);
    tick();
    check("beq_z1_fetch", State, 3'd0);
    Zero = 1'b0;
    tick(); tick();
    check("beq_z0_pcwrite", PCWrite, 1'b0);
    check("beq_z0_taken", BranchTaken, 1'b0);
    tick();
    check("beq_z0_fetch", State, 3'd0);
`else
    Zero = 1'b1;
    tick(); tick();
    check("beq_off_state", State, 3'd5);
    check("beq_off_cause", TrapCause, 2'b01);
    check("beq_off_taken", BranchTaken, 1'b0);
    TrapAck = 1'b1;
    tick();
    TrapAck = 1'b0;
    Zero = 1'b0;
    #1;
    check("beq_off_ack", State, 3'd0);
`endif

    // Reset during MEM of a store with MemReady low
    Opcode = 7'b0100011;
    MemReady = 1'b1;
    tick(); tick();
    MemReady = 1'b0;
    tick(); tick();
    check("rmem_state", State, 3'd3);
    check("rmem_memwrite", MemWrite, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rmem_async_memwrite", MemWrite, 1'b0);
    check("rmem_async_memread", MemRead, 1'b0);
    check("rmem_async_state", State, 3'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rmem_rel_memread", MemRead, 1'b1);
    check("rmem_rel_memwrite", MemWrite, 1'b0);
    tick();
    check("rmem_wait_state", State, 3'd0);
    check("rmem_wait_memwrite", MemWrite, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
